// File: rtl/led_cursor_pkg.sv
// Shared definitions for the LED cursor controller: mode encoding, direction bit
// indices, panel limits and a saturating coordinate step helper.
package led_cursor_pkg;

  localparam logic [0:0] MODE_MANUAL = 1'b0;
  localparam logic [0:0] MODE_AUTO   = 1'b1;

  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  localparam int unsigned LED_X_MAX = 15;
  localparam int unsigned LED_Y_MAX = 7;

  // One step along an axis; opposite requests cancel, result clamps to [0, max].
  function automatic logic [3:0] sat_step(input logic [3:0] v, input logic inc,
                                          input logic dec, input logic [3:0] max);
    logic [3:0] r;
    r = v;
    if (inc && !dec && (v < max)) begin
      r = v + 4'd1;
    end else if (dec && !inc && (v != 4'd0)) begin
      r = v - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running step prescaler: registered one-cycle tick every STEP_DIV clocks.
module step_prescaler #(
  parameter int unsigned STEP_DIV = 1_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(STEP_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= wrap;
    end
  end

endmodule

// File: rtl/led_cursor_ctrl.sv
// Cursor controller for the 16x8 LED dot driver: key/sensor request mux, manual
// moves on step ticks, idle timeout into an automatic raster sweep.
module led_cursor_ctrl
  import led_cursor_pkg::*;
#(
  parameter int unsigned STEP_DIV   = 1_500_000,
  parameter int unsigned IDLE_STEPS = 40,
  parameter int unsigned X_MAX      = LED_X_MAX,
  parameter int unsigned Y_MAX      = LED_Y_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_dir,
  input  logic       sns_en,
  input  logic [3:0] sns_dir,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       auto_mode,
  output logic       step_tick
);

  localparam int unsigned IW = $clog2(IDLE_STEPS + 1);

  logic          tick;
  logic [3:0]    req;
  logic [3:0]    x_q, x_d, y_q, y_d;
  logic [3:0]    mx, my;
  logic [0:0]    mode_q, mode_d;
  logic [IW-1:0] idle_q, idle_d;

  step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Any key press masks the sensor completely, even if the keys cancel out.
  always_comb begin
    if (key_dir != 4'd0) begin
      req = key_dir;
    end else if (sns_en) begin
      req = sns_dir;
    end else begin
      req = 4'd0;
    end
  end

  always_comb begin
    mx = sat_step(x_q, req[DIR_RIGHT], req[DIR_LEFT], 4'(X_MAX));
    my = sat_step(y_q, req[DIR_UP], req[DIR_DOWN], 4'(Y_MAX));
  end

  always_comb begin
    mode_d = mode_q;
    idle_d = idle_q;
    x_d    = x_q;
    y_d    = y_q;
    if (mode_q == MODE_MANUAL) begin
      if (tick) begin
        if (req == 4'd0) begin
          if (idle_q == IW'(IDLE_STEPS - 1)) begin
            mode_d = MODE_AUTO;
            idle_d = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end else begin
          x_d    = mx;
          y_d    = my;
          idle_d = '0;
        end
      end
    end else if (req != 4'd0) begin
      // Leaving the sweep is immediate; a coincident tick moves manually instead.
      mode_d = MODE_MANUAL;
      idle_d = '0;
      if (tick) begin
        x_d = mx;
        y_d = my;
      end
    end else if (tick) begin
      if (x_q == 4'(X_MAX)) begin
        x_d = 4'd0;
        y_d = (y_q == 4'(Y_MAX)) ? 4'd0 : y_q + 4'd1;
      end else begin
        x_d = x_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_MANUAL;
      idle_q <= '0;
      x_q    <= 4'd0;
      y_q    <= 4'd0;
    end else begin
      mode_q <= mode_d;
      idle_q <= idle_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign auto_mode = (mode_q == MODE_AUTO);
  assign step_tick = tick;

endmodule

// File: tb/tb_led_cursor_ctrl.sv
// Self-checking bench for led_cursor_ctrl: directed scenarios then randomized
// stimulus, compared each cycle against an arithmetic cursor model.
module tb_led_cursor_ctrl;

  localparam int DIV  = 4;
  localparam int IDLE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_dir;
  logic       sns_en;
  logic [3:0] sns_dir;
  logic [3:0] x, y;
  logic       auto_mode, step_tick;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: cursor position, sweep flag, idle ticks, edges since reset release.
  int m_x, m_y, m_auto, m_idle, m_edges;
  bit last_tk;

  led_cursor_ctrl #(
    .STEP_DIV  (DIV),
    .IDLE_STEPS(IDLE),
    .X_MAX     (15),
    .Y_MAX     (7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_dir  (key_dir),
    .sns_en   (sns_en),
    .sns_dir  (sns_dir),
    .x        (x),
    .y        (y),
    .auto_mode(auto_mode),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".x"}, 32'(x), 32'(m_x));
    chk({tag, ".y"}, 32'(y), 32'(m_y));
    chk({tag, ".auto"}, 32'(auto_mode), 32'(m_auto));
    chk({tag, ".tick"}, 32'(step_tick), (m_edges > 0 && m_edges % DIV == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_auto = 0; m_idle = 0; m_edges = 0;
  endtask

  // Advance one clock; the model is evaluated from the inputs seen before the edge.
  task automatic cyc();
    int r, dx, dy, nx, ny, na, ni, lin;
    bit tk;
    r  = (key_dir != 0) ? int'(key_dir) : (sns_en ? int'(sns_dir) : 0);
    tk = (m_edges > 0) && (m_edges % DIV == 0);
    dx = int'(r[0]) - int'(r[1]);
    dy = int'(r[3]) - int'(r[2]);
    nx = m_x + dx; nx = (nx < 0) ? 0 : (nx > 15) ? 15 : nx;
    ny = m_y + dy; ny = (ny < 0) ? 0 : (ny > 7) ? 7 : ny;
    na = m_auto; ni = m_idle;
    if (m_auto == 0) begin
      if (tk && r == 0) begin
        ni = m_idle + 1;
        if (ni == IDLE) begin na = 1; ni = 0; end
        nx = m_x; ny = m_y;
      end else if (tk) begin
        ni = 0;
      end else begin
        nx = m_x; ny = m_y;
      end
    end else if (r != 0) begin
      na = 0; ni = 0;
      if (!tk) begin nx = m_x; ny = m_y; end
    end else if (tk) begin
      lin = (m_y * 16 + m_x + 1) % 128;
      nx = lin % 16; ny = lin / 16;
    end else begin
      nx = m_x; ny = m_y;
    end
    @(posedge clk);
    #1;
    m_x = nx; m_y = ny; m_auto = na; m_idle = ni; m_edges++;
    last_tk = tk;
    chk_all("cyc");
  endtask

  task automatic run_ticks(input int n);
    int c = 0;
    while (c < n) begin
      cyc();
      if (last_tk) c++;
    end
  endtask

  task automatic set_in(input logic [3:0] k, input logic se, input logic [3:0] sd);
    key_dir = k; sns_en = se; sns_dir = sd;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk_all("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    set_in(4'd0, 1'b0, 4'd0);
    rst = 1'b1;
    #1;
    do_reset();

    // Idle after reset: first tick at cycle 4, position held.
    repeat (3) cyc();
    chk("pre_tick", 32'(step_tick), 32'd0);
    cyc();
    chk("first_tick", 32'(step_tick), 32'd1);
    repeat (4) cyc();
    chk("second_tick", 32'(step_tick), 32'd1);

    // Hold right: sweep (if entered) ends, x saturates at 15.
    set_in(4'b0001, 1'b0, 4'd0);
    run_ticks(20);
    chk("right_sat.x", 32'(x), 32'd15);
    chk("right_sat.auto", 32'(auto_mode), 32'd0);

    // Cancelling keys mask the sensor; nothing moves and idle does not advance.
    set_in(4'b0011, 1'b1, 4'b1000);
    run_ticks(8);
    chk("cancel.x", 32'(x), 32'd15);
    chk("cancel.auto", 32'(auto_mode), 32'd0);

    // Walk to (14,7), then idle into the sweep.
    set_in(4'b1000, 1'b0, 4'd0);
    run_ticks(8);
    set_in(4'b0010, 1'b0, 4'd0);
    run_ticks(1);
    chk("corner.x", 32'(x), 32'd14);
    chk("corner.y", 32'(y), 32'd7);
    set_in(4'd0, 1'b0, 4'd0);
    run_ticks(3);
    chk("auto_on", 32'(auto_mode), 32'd1);
    run_ticks(1);
    chk("sweep1", {28'd0, x} * 16 + 32'(y), 32'd15 * 16 + 32'd7);
    run_ticks(1);
    chk("sweep2", {28'd0, x} * 16 + 32'(y), 32'd0);
    run_ticks(1);
    chk("sweep3", {28'd0, x} * 16 + 32'(y), 32'd16);

    // One-cycle sensor request between ticks drops out of the sweep.
    set_in(4'd0, 1'b1, 4'b0100);
    cyc();
    chk("exit.auto", 32'(auto_mode), 32'd0);
    chk("exit.x", 32'(x), 32'd1);
    set_in(4'd0, 1'b0, 4'd0);
    run_ticks(2);
    chk("idle_restart", 32'(auto_mode), 32'd0);
    run_ticks(1);
    chk("auto_again", 32'(auto_mode), 32'd1);

    // Reset in the middle of the sweep at (5,2).
    for (int i = 0; i < 200 && !(m_x == 5 && m_y == 2); i++) run_ticks(1);
    chk("at_5_2", {28'd0, x} * 16 + 32'(y), 32'd5 * 16 + 32'd2);
    do_reset();
    repeat (4) cyc();
    chk("tick_after_rst", 32'(step_tick), 32'd1);

    // Randomized traffic, mostly idle so the sweep is exercised too.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0, 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0);
      repeat ($urandom_range(1, 6)) cyc();
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
